// File: rtl/gcn_pkg.sv
// gcn_pkg: shared constants, index widths and scheduler state type for the FM x WM stage
package gcn_pkg;
   localparam int FEATURE_COLS = 96;
   localparam int FEATURE_ROWS = 6;
   localparam int WEIGHT_COLS = 3;
   localparam int ELEM_WIDTH = 5;
   localparam int DOT_PROD_WIDTH = 16;
   localparam int F_ADDR_W = $clog2(FEATURE_ROWS * FEATURE_COLS);
   localparam int W_ADDR_W = $clog2(WEIGHT_COLS * FEATURE_COLS);
   localparam int ROW_W = $clog2(FEATURE_ROWS);
   localparam int COL_W = $clog2(WEIGHT_COLS);
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, WRITE, DONE} sched_state_t;
endpackage

// File: rtl/vector_operand_scheduler_load.sv
// vector_load_unit: streams N elements from a synchronous-read memory into an operand register vector
module vector_load_unit
   import gcn_pkg::*;
#(
   parameter int AW = 9,
   parameter int N = FEATURE_COLS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [AW-1:0]         base,
   input  logic [ELEM_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic [AW-1:0]         rd_addr,
   output logic [ELEM_WIDTH-1:0] vec [N],
   output logic                  last
);
   localparam int K_W = $clog2(N + 1);
   logic active;
   logic [K_W-1:0] k;
   assign last = active && k == K_W'(N);
   // read issued at step k returns at step k+1, so capture trails the address by one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active <= 1'b0;
         k <= '0;
         rd_en <= 1'b0;
         rd_addr <= '0;
         for (int i = 0; i < N; i++) vec[i] <= '0;
      end else if (load) begin
         active <= 1'b1;
         k <= '0;
         rd_en <= 1'b1;
         rd_addr <= base;
      end else if (active) begin
         if (k != '0) vec[k - 1'b1] <= rd_data;
         active <= !last;
         k <= last ? '0 : k + 1'b1;
         rd_en <= k < K_W'(N - 1);
         rd_addr <= k < K_W'(N - 1) ? rd_addr + 1'b1 : rd_addr;
      end
   end
endmodule

// File: rtl/vector_operand_scheduler.sv
// vector_operand_scheduler: loads weight column / feature row operand vectors for the
// dot-product unit and writes every (row, col) result into the FM_WM buffer.
module vector_operand_scheduler
   import gcn_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      weight_en,
   output logic [W_ADDR_W-1:0]       weight_addr,
   input  logic [ELEM_WIDTH-1:0]     weight_data,
   output logic                      feature_en,
   output logic [F_ADDR_W-1:0]       feature_addr,
   input  logic [ELEM_WIDTH-1:0]     feature_data,
   output logic [ELEM_WIDTH-1:0]     feature_row_out [FEATURE_COLS],
   output logic [ELEM_WIDTH-1:0]     weight_col_out [FEATURE_COLS],
   input  logic [DOT_PROD_WIDTH-1:0] fm_wm_in,
   output logic                      fm_wm_wr_en,
   output logic [ROW_W-1:0]          fm_wm_wr_row,
   output logic [COL_W-1:0]          fm_wm_wr_col,
   output logic [DOT_PROD_WIDTH-1:0] fm_wm_wr_data,
   output logic                      busy,
   output logic                      done
);
   sched_state_t state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic w_load, f_load, w_last, f_last, last_row, last_col;
   logic [W_ADDR_W-1:0] w_base;
   logic [F_ADDR_W-1:0] f_base;
   // load pulses and bases are issued one cycle ahead so the first address lines up with k=0
   always_comb begin
      last_row = row == ROW_W'(FEATURE_ROWS - 1);
      last_col = col == COL_W'(WEIGHT_COLS - 1);
      w_load = (state == IDLE && start) || (state == WRITE && last_row && !last_col);
      f_load = (state == LOAD_W && w_last) || (state == WRITE && !last_row);
      w_base = state == IDLE ? '0 : W_ADDR_W'((32'(col) + 1) * FEATURE_COLS);
      f_base = F_ADDR_W'((32'(row) + (state == WRITE ? 1 : 0)) * FEATURE_COLS);
   end
   assign fm_wm_wr_data = fm_wm_wr_en ? fm_wm_in : '0;
   vector_load_unit #(.AW(W_ADDR_W), .N(FEATURE_COLS)) u_weight (
      .clk(clk), .rst_n(rst_n), .load(w_load), .base(w_base), .rd_data(weight_data),
      .rd_en(weight_en), .rd_addr(weight_addr), .vec(weight_col_out), .last(w_last)
   );
   vector_load_unit #(.AW(F_ADDR_W), .N(FEATURE_COLS)) u_feature (
      .clk(clk), .rst_n(rst_n), .load(f_load), .base(f_base), .rd_data(feature_data),
      .rd_en(feature_en), .rd_addr(feature_addr), .vec(feature_row_out), .last(f_last)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         row <= '0;
         col <= '0;
         fm_wm_wr_en <= 1'b0;
         fm_wm_wr_row <= '0;
         fm_wm_wr_col <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         fm_wm_wr_en <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= LOAD_W;
               row <= '0;
               col <= '0;
               busy <= 1'b1;
            end
            LOAD_W: if (w_last) state <= LOAD_F;
            LOAD_F: if (f_last) begin
               state <= WRITE;
               fm_wm_wr_en <= 1'b1;
               fm_wm_wr_row <= row;
               fm_wm_wr_col <= col;
            end
            WRITE: if (!last_row) begin
               row <= row + 1'b1;
               state <= LOAD_F;
            end else if (!last_col) begin
               row <= '0;
               col <= col + 1'b1;
               state <= LOAD_W;
            end else begin
               state <= DONE;
               done <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/vector_operand_scheduler.md
Name: vector_operand_scheduler

Overview:
- Initiator and result sink for the combinational dot-product datapath in the FM×WM stage of the GCN accelerator.
- Streams one weight column and one feature row, one element per cycle, from synchronous-read memories into operand registers.
- Presents both vectors to the dot-product unit and captures the returned dot product.
- Writes each result into the FM_WM buffer at (row, col), iterating over all FEATURE_ROWS × WEIGHT_COLS pairs.

Parameters:
- FEATURE_COLS, 96, vector length N (elements per row/column)
- FEATURE_ROWS, 6, feature matrix rows
- WEIGHT_COLS, 3, weight matrix columns
- ELEM_WIDTH, 5, operand element width
- DOT_PROD_WIDTH, 16, dot-product/result width
- F_ADDR_W, $clog2(FEATURE_ROWS*FEATURE_COLS), feature memory address width (10)
- W_ADDR_W, $clog2(WEIGHT_COLS*FEATURE_COLS), weight memory address width (9)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a full matrix pass; sampled only in IDLE
- weight_en  out  1  weight memory read enable
- weight_addr  out  W_ADDR_W  weight address = col*N + k (column-major)
- weight_data  in  ELEM_WIDTH  read data, valid the cycle after weight_en
- feature_en  out  1  feature memory read enable
- feature_addr  out  F_ADDR_W  feature address = row*N + k
- feature_data  in  ELEM_WIDTH  read data, valid the cycle after feature_en
- feature_row_out  out  ELEM_WIDTH x N  unpacked operand vector to the dot-product unit
- weight_col_out  out  ELEM_WIDTH x N  unpacked operand vector to the dot-product unit
- fm_wm_in  in  DOT_PROD_WIDTH  combinational dot product of the two vectors
- fm_wm_wr_en  out  1  result write strobe
- fm_wm_wr_row  out  $clog2(FEATURE_ROWS)  result row index
- fm_wm_wr_col  out  $clog2(WEIGHT_COLS)  result column index
- fm_wm_wr_data  out  DOT_PROD_WIDTH  result data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (rst_n=0 at an edge):
  - state←IDLE; all counters, vectors, addresses, enables, wr_* outputs, busy and done←0.
  - Applies from any state; an in-flight pass is abandoned with no partial writes afterwards.
- States: IDLE, LOAD_W, LOAD_F, WRITE, DONE.
- IDLE: start=1 → LOAD_W with col=0, row=0, k=0. Otherwise stay in IDLE.
- LOAD_W: N+1 cycles, k=0..N.
  - For k<N: weight_en=1, weight_addr=col*N+k.
  - For k≥1: weight_col_out[k-1]←weight_data.
  - At k=N → LOAD_F with k=0.
- LOAD_F: same N+1-cycle pattern on the feature port (feature_addr=row*N+k), filling feature_row_out.
  - At k=N → WRITE.
- WRITE: one cycle.
  - fm_wm_wr_en=1, wr_row=row, wr_col=col, wr_data=fm_wm_in (vectors are stable through this cycle).
  - If row<FEATURE_ROWS-1: row++ → LOAD_F.
  - Else if col<WEIGHT_COLS-1: row=0, col++ → LOAD_W.
  - Else → DONE.
- DONE: done=1 for one cycle → IDLE. Vectors hold their last values.
- Enables are 0 outside load-issue cycles. Addresses hold their last value when the enable is low.
- The weight column is loaded once per column and reused across all rows.
- Latency with defaults:
  - Per column: (N+1) + FEATURE_ROWS*(N+2) = 685 cycles.
  - If start is sampled at cycle 0, LOAD_W begins at cycle 1, the last WRITE is at cycle 2055, and done is at cycle 2056.
- start while busy is ignored. start in the DONE cycle is ignored. start held high after a pass re-launches from IDLE.
- Arithmetic: no computation in this block. wr_data is fm_wm_in passed through unmodified, with no saturation; overflow is the datapath's concern. Index counters wrap only via explicit state transitions and never exceed their bounds.

Decomposition:
- Package gcn_pkg holds:
  - constants: FEATURE_COLS, FEATURE_ROWS, WEIGHT_COLS, ELEM_WIDTH, DOT_PROD_WIDTH
  - derived address/index widths
  - state enum type sched_state_t
- One natural sub-module, vector_load_unit: counter k, read-enable/address generation from a base address, and the one-cycle-delayed capture into an N-entry register vector.
  - Instantiated twice (weight, feature).
  - Controlled by a load pulse and returns a last flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, busy=0, no enables.
- All-ones memories, start pulse → 18 writes, each wr_data=96. Order is (r,c) = (0,0),(1,0)..(5,0),(0,1)..(5,2). done at cycle 2056.
- Feature[r][k]=r+1, weight[c][k]=1 if k==c else 0 → wr_data at (r,c) = r+1. Exactly 3 LOAD_W phases (weight_en high 288 cycles total) and 18 LOAD_F phases.
- Max values, all elements 31 → wr_data = 96*961 mod 2^16 = 26720 at every (r,c). Address sequences checked: weight 0..287, feature 0..575 repeated per column.
- start re-pulsed at cycle 500 during a pass → ignored. Write count stays 18, done exactly once.
- rst_n=0 at cycle 1000 for one cycle → IDLE next cycle, no further writes. A new start then completes a full 18-write pass with correct results.
